// File: rtl/id_imm_ctrl_if.sv
// ============================================================================
// Module : id_imm_ctrl_if
// Brief  : Fetch-side and execute-side handshake bundle for id_imm_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface id_imm_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [63:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_inst;
    logic [63:0] out_imm;
    logic        out_illegal;

    // Stage side: consumes fetch requests, produces execute payload.
    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_inst, out_imm, out_illegal
    );

    // Environment side: drives fetch and accepts execute payload.
    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_inst, out_imm, out_illegal
    );
endinterface

`default_nettype wire

// File: rtl/id_imm_ctrl.sv
// ============================================================================
// Module : id_imm_ctrl
// Brief  : Single-entry decode stage that holds one instruction, extracts its
//          immediate fields and classifies the immediate format.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module id_imm_ctrl (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         flush,
    id_imm_ctrl_if.slave      bus,
    output logic      [11:0]  imm_i_l_jalr,
    output logic      [11:0]  imm_s,
    output logic      [11:0]  imm_b,
    output logic      [19:0]  imm_jal,
    output logic      [19:0]  imm_u,
    output logic      [3:0]   imm_sel,
    input  wire logic [63:0]  imm_val,
    output logic      [31:0]  inst_cnt
);

    localparam logic [0:0]  c_ST_EMPTY = 1'b0;
    localparam logic [0:0]  c_ST_FULL  = 1'b1;
    localparam logic [31:0] c_NOP      = 32'h0000_0013;

    logic [0:0]  r_state;
    logic [0:0]  w_state_nxt;
    logic [31:0] r_inst;
    logic [63:0] r_pc;
    logic [31:0] r_inst_cnt;

    logic        w_vld;
    logic        w_in_ready;
    logic        w_accept;
    logic        w_out_valid;
    logic        w_fire;
    logic [3:0]  w_sel_raw;
    logic        w_illegal_raw;
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;

    assign w_vld    = (r_state == c_ST_FULL);
    assign w_accept = bus.in_valid && w_in_ready;
    assign w_fire   = w_out_valid && bus.out_ready;
    assign w_opcode = r_inst[6:0];
    assign w_funct3 = r_inst[14:12];

    // State register plus the held payload and delivery counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_EMPTY;
            r_inst     <= c_NOP;
            r_pc       <= 64'd0;
            r_inst_cnt <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_inst <= bus.in_inst;
                r_pc   <= bus.in_pc;
            end
            if (w_fire) begin
                r_inst_cnt <= r_inst_cnt + 32'd1;
            end
        end
    end

    // Next-state logic; flush discards whatever is held.
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = c_ST_EMPTY;
        end else begin
            case (r_state)
                c_ST_EMPTY: if (w_accept) w_state_nxt = c_ST_FULL;
                c_ST_FULL:  if (bus.out_ready && !w_accept) w_state_nxt = c_ST_EMPTY;
                default:    w_state_nxt = c_ST_EMPTY;
            endcase
        end
    end

    // Output logic: handshake and immediate-format classification.
    always_comb begin
        w_in_ready    = !flush && (!w_vld || bus.out_ready);
        w_out_valid   = w_vld && !flush;
        w_sel_raw     = 4'd0;
        w_illegal_raw = 1'b0;
        if (r_inst[1:0] != 2'b11) begin
            w_illegal_raw = 1'b1;
        end else begin
            case (w_opcode)
                7'b0000011, 7'b1100111: w_sel_raw = 4'd1;
                7'b0010011, 7'b0011011:
                    w_sel_raw = (w_funct3 == 3'b001 || w_funct3 == 3'b101) ? 4'd6 : 4'd1;
                7'b0100011:             w_sel_raw = 4'd2;
                7'b1100011:             w_sel_raw = 4'd3;
                7'b1101111:             w_sel_raw = 4'd4;
                7'b0110111, 7'b0010111: w_sel_raw = 4'd5;
                7'b0110011, 7'b0111011,
                7'b1110011, 7'b0001111: w_sel_raw = 4'd0;
                default:                w_illegal_raw = 1'b1;
            endcase
        end
        imm_sel         = w_vld ? w_sel_raw : 4'd0;
        bus.out_illegal = w_vld && w_illegal_raw;
    end

    assign imm_i_l_jalr = r_inst[31:20];
    assign imm_s        = {r_inst[31:25], r_inst[11:7]};
    assign imm_b        = {r_inst[31], r_inst[7], r_inst[30:25], r_inst[11:8]};
    assign imm_jal      = {r_inst[31], r_inst[19:12], r_inst[20], r_inst[30:21]};
    assign imm_u        = r_inst[31:12];

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_pc    = r_pc;
    assign bus.out_inst  = r_inst;
    assign bus.out_imm   = imm_val;
    assign inst_cnt      = r_inst_cnt;

endmodule

`default_nettype wire

// File: tb/tb_id_imm_ctrl.sv
// ============================================================================
// Module : tb_id_imm_ctrl
// Brief  : Directed self-checking bench for id_imm_ctrl with an immediate
//          decoder model closing the imm_* -> imm_val loop.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_id_imm_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [11:0] imm_i_l_jalr;
    logic [11:0] imm_s;
    logic [11:0] imm_b;
    logic [19:0] imm_jal;
    logic [19:0] imm_u;
    logic [3:0]  imm_sel;
    logic [63:0] imm_val;
    logic [31:0] inst_cnt;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_cnt = 32'd0;

    id_imm_ctrl_if bus ();

    id_imm_ctrl u_dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .bus          (bus.slave),
        .imm_i_l_jalr (imm_i_l_jalr),
        .imm_s        (imm_s),
        .imm_b        (imm_b),
        .imm_jal      (imm_jal),
        .imm_u        (imm_u),
        .imm_sel      (imm_sel),
        .imm_val      (imm_val),
        .inst_cnt     (inst_cnt)
    );

    always #5 clk = ~clk;

    // Immediate decoder model: sign-extends by format, shamt is zero-extended.
    always_comb begin
        imm_val = 64'd0;
        case (imm_sel)
            4'd1: imm_val = {{52{imm_i_l_jalr[11]}}, imm_i_l_jalr};
            4'd2: imm_val = {{52{imm_s[11]}}, imm_s};
            4'd3: imm_val = {{51{imm_b[11]}}, imm_b, 1'b0};
            4'd4: imm_val = {{43{imm_jal[19]}}, imm_jal, 1'b0};
            4'd5: imm_val = {{32{imm_u[19]}}, imm_u, 12'd0};
            4'd6: imm_val = {58'd0, imm_i_l_jalr[5:0]};
            default: imm_val = 64'd0;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Load one instruction with out_ready=1, check the held payload, then let it drain.
    task automatic deliver(input logic [31:0] inst, input logic [63:0] pc,
                           input logic [3:0] sel, input logic [63:0] imm,
                           input logic ill);
        bus.in_valid  = 1'b1;
        bus.in_inst   = inst;
        bus.in_pc     = pc;
        bus.out_ready = 1'b1;
        #1;
        check("in_ready_empty", {63'd0, bus.in_ready}, 64'd1);
        step();
        bus.in_valid = 1'b0;
        #1;
        check("out_valid", {63'd0, bus.out_valid}, 64'd1);
        check("out_inst", {32'd0, bus.out_inst}, {32'd0, inst});
        check("out_pc", bus.out_pc, pc);
        check("imm_sel", {60'd0, imm_sel}, {60'd0, sel});
        check("out_imm", bus.out_imm, imm);
        check("out_illegal", {63'd0, bus.out_illegal}, {63'd0, ill});
        step();
        exp_cnt = exp_cnt + 32'd1;
        check("inst_cnt", {32'd0, inst_cnt}, {32'd0, exp_cnt});
        check("drained", {63'd0, bus.out_valid}, 64'd0);
    endtask

    initial begin
        rst           = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_inst   = 32'd0;
        bus.in_pc     = 64'd0;
        bus.out_ready = 1'b0;
        step();
        step();
        check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        check("rst_illegal", {63'd0, bus.out_illegal}, 64'd0);
        check("rst_imm_sel", {60'd0, imm_sel}, 64'd0);
        check("rst_inst_cnt", {32'd0, inst_cnt}, 64'd0);
        check("rst_inst", {32'd0, bus.out_inst}, 64'h13);
        check("rst_pc", bus.out_pc, 64'd0);
        rst = 1'b0;
        step();

        deliver(32'hFFF0_0093, 64'h1000, 4'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        deliver(32'hFE00_0EE3, 64'h1004, 4'd3, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        deliver(32'h1234_52B7, 64'h1008, 4'd5, 64'h0000_0000_1234_5000, 1'b0);
        deliver(32'h03F0_D093, 64'h100C, 4'd6, 64'h0000_0000_0000_003F, 1'b0);
        deliver(32'h0000_007F, 64'h1010, 4'd0, 64'd0, 1'b1);
        deliver(32'h0000_0012, 64'h1014, 4'd0, 64'd0, 1'b1);
        deliver(32'h0080_00EF, 64'h1018, 4'd4, 64'h8, 1'b0);
        deliver(32'hFE11_2E23, 64'h101C, 4'd2, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);

        // beq field extraction while held
        bus.in_valid  = 1'b1;
        bus.in_inst   = 32'hFE00_0EE3;
        bus.out_ready = 1'b0;
        step();
        bus.in_valid = 1'b0;
        #1;
        check("imm_b", {52'd0, imm_b}, 64'hFFE);
        bus.out_ready = 1'b1;
        step();
        exp_cnt = exp_cnt + 32'd1;
        check("cnt_beq", {32'd0, inst_cnt}, {32'd0, exp_cnt});

        // Stall for 5 cycles with the next instruction waiting upstream
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_inst   = 32'h0010_0113;
        bus.in_pc     = 64'h2000;
        step();
        bus.in_inst = 32'h0020_0193;
        bus.in_pc   = 64'h2004;
        #1;
        check("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_inst", {32'd0, bus.out_inst}, 64'h0010_0113);
            check("stall_pc", bus.out_pc, 64'h2000);
            check("stall_imm", bus.out_imm, 64'd1);
            check("stall_cnt", {32'd0, inst_cnt}, {32'd0, exp_cnt});
        end
        bus.out_ready = 1'b1;
        step();
        exp_cnt = exp_cnt + 32'd1;
        check("b2b_inst1", {32'd0, bus.out_inst}, 64'h0020_0193);
        check("b2b_valid1", {63'd0, bus.out_valid}, 64'd1);
        check("b2b_cnt1", {32'd0, inst_cnt}, {32'd0, exp_cnt});
        bus.in_inst = 32'h0030_0213;
        bus.in_pc   = 64'h2008;
        step();
        exp_cnt = exp_cnt + 32'd1;
        check("b2b_inst2", {32'd0, bus.out_inst}, 64'h0030_0213);
        check("b2b_pc2", bus.out_pc, 64'h2008);
        check("b2b_cnt2", {32'd0, inst_cnt}, {32'd0, exp_cnt});
        bus.in_valid = 1'b0;
        step();
        exp_cnt = exp_cnt + 32'd1;
        check("b2b_cnt3", {32'd0, inst_cnt}, {32'd0, exp_cnt});
        check("b2b_empty", {63'd0, bus.out_valid}, 64'd0);
        check("empty_sel", {60'd0, imm_sel}, 64'd0);

        // Flush while FULL and stalled, with a concurrent input offered
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_inst   = 32'h0040_0293;
        step();
        flush       = 1'b1;
        bus.in_inst = 32'h0050_0313;
        #1;
        check("flush_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("flush_in_ready", {63'd0, bus.in_ready}, 64'd0);
        step();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("post_flush_valid", {63'd0, bus.out_valid}, 64'd0);
        check("post_flush_cnt", {32'd0, inst_cnt}, {32'd0, exp_cnt});

        // Reset in the middle of a stall
        bus.in_valid = 1'b1;
        bus.in_inst  = 32'h0060_0393;
        step();
        bus.in_valid = 1'b0;
        step();
        check("pre_rst_valid", {63'd0, bus.out_valid}, 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("mid_rst_valid", {63'd0, bus.out_valid}, 64'd0);
        check("mid_rst_cnt", {32'd0, inst_cnt}, 64'd0);
        check("mid_rst_inst", {32'd0, bus.out_inst}, 64'h13);
        check("mid_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
